// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs drained round-robin onto
// N_CDB registered broadcast ports, with back-pressure when a FIFO is full.
package cdb_arbiter_pkg;
  localparam int unsigned EX_UNITS    = 4;
  localparam int unsigned EX_ROB_ID_W = 5;

  typedef struct packed {
    logic                   ready;
    logic [EX_ROB_ID_W-1:0] rob_id;
    logic [31:0]            rd_data;
  } ex_data_bus_t;
endpackage

module cdb_arbiter #(
  parameter int unsigned N_SRC    = cdb_arbiter_pkg::EX_UNITS,
  parameter int unsigned N_CDB    = 1,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ROB_ID_W = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_flush,
  input  cdb_arbiter_pkg::ex_data_bus_t i_ex_bus     [N_SRC],
  output logic [N_SRC-1:0]              o_ex_stall,
  output logic [N_CDB-1:0]              o_cdb_valid,
  output logic [ROB_ID_W-1:0]           o_cdb_rob_id [N_CDB],
  output logic [31:0]                   o_cdb_data   [N_CDB]
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned KW = (N_CDB > 1) ? $clog2(N_CDB) : 1;

  logic [ROB_ID_W-1:0] r_mem_id   [N_SRC][DEPTH];
  logic [31:0]         r_mem_data [N_SRC][DEPTH];
  logic [PW-1:0]       r_head     [N_SRC];
  logic [PW-1:0]       r_tail     [N_SRC];
  logic [CW-1:0]       r_count    [N_SRC];
  logic [SW-1:0]       r_rr_ptr;

  logic [N_SRC-1:0]    w_push;
  logic [N_SRC-1:0]    w_grant;
  logic [N_CDB-1:0]    w_port_vld;
  logic [SW-1:0]       w_port_src [N_CDB];
  logic                w_any;
  logic [SW-1:0]       w_rr_next;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    // Stall comes from the registered count only, so a same-cycle pop
    // cannot release it and there is no path from i_ex_bus to o_ex_stall.
    assign o_ex_stall[gi] = (r_count[gi] == CW'(DEPTH));
    assign w_push[gi]     = i_ex_bus[gi].ready && !o_ex_stall[gi];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_head[gi]  <= '0;
        r_tail[gi]  <= '0;
        r_count[gi] <= '0;
      end else if (i_flush) begin
        r_head[gi]  <= '0;
        r_tail[gi]  <= '0;
        r_count[gi] <= '0;
      end else begin
        if (w_push[gi])  r_tail[gi] <= r_tail[gi] + PW'(1);
        if (w_grant[gi]) r_head[gi] <= r_head[gi] + PW'(1);
        r_count[gi] <= r_count[gi] + CW'(w_push[gi]) - CW'(w_grant[gi]);
      end
    end

    always_ff @(posedge i_clk) begin
      if (w_push[gi] && !i_flush) begin
        r_mem_id[gi][r_tail[gi]]   <= ROB_ID_W'(i_ex_bus[gi].rob_id);
        r_mem_data[gi][r_tail[gi]] <= i_ex_bus[gi].rd_data;
      end
    end
  end

  always_comb begin
    int unsigned n;
    int unsigned idx;
    int unsigned last;
    w_grant    = '0;
    w_port_vld = '0;
    w_port_src = '{default: '0};
    n          = 0;
    idx        = 0;
    last       = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(r_rr_ptr) + k) % N_SRC;
      if ((r_count[SW'(idx)] != '0) && (n < N_CDB)) begin
        w_grant[SW'(idx)]    = 1'b1;
        w_port_vld[KW'(n)]   = 1'b1;
        w_port_src[KW'(n)]   = SW'(idx);
        last                 = idx;
        n                    = n + 1;
      end
    end
    w_any     = (n != 0);
    w_rr_next = SW'((last + 1) % N_SRC);
  end

  for (genvar gk = 0; gk < N_CDB; gk++) begin : g_port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        o_cdb_valid[gk]  <= 1'b0;
        o_cdb_rob_id[gk] <= '0;
        o_cdb_data[gk]   <= '0;
      end else if (i_flush) begin
        o_cdb_valid[gk]  <= 1'b0;
      end else begin
        o_cdb_valid[gk] <= w_port_vld[gk];
        if (w_port_vld[gk]) begin
          o_cdb_rob_id[gk] <= r_mem_id[w_port_src[gk]][r_head[w_port_src[gk]]];
          o_cdb_data[gk]   <= r_mem_data[w_port_src[gk]][r_head[w_port_src[gk]]];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (!i_flush && w_any) begin
      r_rr_ptr <= w_rr_next;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a single-port and a dual-port instance,
// each step checked against hand-computed broadcast order and stall state.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  ex_data_bus_t bus1 [4];
  ex_data_bus_t bus2 [4];
  logic [3:0]   stall1, stall2;
  logic [0:0]   vld1;
  logic [1:0]   vld2;
  logic [4:0]   rob1 [1];
  logic [4:0]   rob2 [2];
  logic [31:0]  dat1 [1];
  logic [31:0]  dat2 [2];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(4), .N_CDB(1), .DEPTH(2), .ROB_ID_W(5)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_ex_bus(bus1),
    .o_ex_stall(stall1), .o_cdb_valid(vld1), .o_cdb_rob_id(rob1), .o_cdb_data(dat1)
  );

  cdb_arbiter #(.N_SRC(4), .N_CDB(2), .DEPTH(2), .ROB_ID_W(5)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_ex_bus(bus2),
    .o_ex_stall(stall2), .o_cdb_valid(vld2), .o_cdb_rob_id(rob2), .o_cdb_data(dat2)
  );

  function automatic logic [31:0] dat(input logic [4:0] r);
    return 32'hC0DE_0000 | {27'd0, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    for (int i = 0; i < 4; i++) begin
      bus1[i] = '0;
      bus2[i] = '0;
    end
  endtask

  task automatic put1(input logic [1:0] u, input logic [4:0] r);
    bus1[u].ready   = 1'b1;
    bus1[u].rob_id  = r;
    bus1[u].rd_data = dat(r);
  endtask

  task automatic put2(input logic [1:0] u, input logic [4:0] r);
    bus2[u].ready   = 1'b1;
    bus2[u].rob_id  = r;
    bus2[u].rd_data = dat(r);
  endtask

  task automatic exp1(input string tag, input logic [4:0] r);
    chk({tag, "_valid"}, 64'(vld1), 64'(1));
    chk({tag, "_rob"},   64'(rob1[0]), 64'(r));
    chk({tag, "_data"},  64'(dat1[0]), 64'(dat(r)));
  endtask

  task automatic idle1(input string tag);
    chk(tag, 64'(vld1), 64'(0));
  endtask

  task automatic do_reset();
    clr_bus();
    flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   ai, bi, k;
    logic acc0, acc1;
    logic [4:0] er;

    clr_bus();
    flush = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_valid1", 64'(vld1), 64'(0));
    chk("rst_stall1", 64'(stall1), 64'(0));
    chk("rst_rob1",   64'(rob1[0]), 64'(0));
    chk("rst_data1",  64'(dat1[0]), 64'(0));
    chk("rst_valid2", 64'(vld2), 64'(0));
    chk("rst_stall2", 64'(stall2), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single push: visible two edges after acceptance, for one cycle only
    bus1[0].ready   = 1'b1;
    bus1[0].rob_id  = 5'd3;
    bus1[0].rd_data = 32'hDEAD_BEEF;
    tick();
    bus1[0] = '0;
    idle1("single_t1");
    tick();
    chk("single_valid", 64'(vld1), 64'(1));
    chk("single_rob",   64'(rob1[0]), 64'(3));
    chk("single_data",  64'(dat1[0]), 64'(32'hDEAD_BEEF));
    tick();
    idle1("single_t3");

    // Round-robin fairness with a late unit-0 result
    do_reset();
    for (int u = 0; u < 4; u++) put1(2'(u), 5'(u));
    tick();
    clr_bus();
    tick();
    exp1("rr_0", 5'd0);
    put1(2'd0, 5'd8);
    tick();
    clr_bus();
    exp1("rr_1", 5'd1);
    tick();
    exp1("rr_2", 5'd2);
    tick();
    exp1("rr_3", 5'd3);
    tick();
    exp1("rr_new0", 5'd8);
    tick();
    idle1("rr_idle");

    // Back-pressure: units 0 and 1 present continuously, 10 results each
    do_reset();
    ai = 0;
    bi = 0;
    for (int c = 1; c <= 21; c++) begin
      if (ai < 10) put1(2'd0, 5'(ai)); else bus1[0] = '0;
      if (bi < 10) put1(2'd1, 5'(16 + bi)); else bus1[1] = '0;
      acc0 = bus1[0].ready && !stall1[0];
      acc1 = bus1[1].ready && !stall1[1];
      tick();
      if (acc0) ai++;
      if (acc1) bi++;
      if (c == 2) chk("bp_stall_e2", 64'(stall1), 64'(4'b0010));
      if (c == 3) chk("bp_stall_e3", 64'(stall1), 64'(4'b0001));
      if (c >= 2) begin
        k  = c - 2;
        er = (k % 2 == 0) ? 5'(k / 2) : 5'(16 + k / 2);
        exp1("bp_seq", er);
      end
    end
    clr_bus();
    tick();
    idle1("bp_idle");
    chk("bp_acc0", 64'(ai), 64'(10));
    chk("bp_acc1", 64'(bi), 64'(10));

    // Dual port: scan order and pointer wrap
    do_reset();
    put2(2'd1, 5'd5);
    put2(2'd2, 5'd6);
    put2(2'd3, 5'd7);
    tick();
    clr_bus();
    chk("dual_t1_valid", 64'(vld2), 64'(0));
    tick();
    chk("dual_a_valid", 64'(vld2), 64'(2'b11));
    chk("dual_a_p0",    64'(rob2[0]), 64'(5));
    chk("dual_a_p1",    64'(rob2[1]), 64'(6));
    chk("dual_a_d1",    64'(dat2[1]), 64'(dat(5'd6)));
    tick();
    chk("dual_b_valid", 64'(vld2), 64'(2'b01));
    chk("dual_b_p0",    64'(rob2[0]), 64'(7));
    chk("dual_b_p1hold", 64'(rob2[1]), 64'(6));
    put2(2'd0, 5'd9);
    put2(2'd3, 5'd10);
    tick();
    clr_bus();
    chk("dual_c_idle", 64'(vld2), 64'(0));
    tick();
    chk("dual_wrap_valid", 64'(vld2), 64'(2'b11));
    chk("dual_wrap_p0",    64'(rob2[0]), 64'(9));
    chk("dual_wrap_p1",    64'(rob2[1]), 64'(10));

    // Flush with two results queued in unit 2 and a push in the flush cycle
    do_reset();
    put1(2'd0, 5'd20);
    put1(2'd1, 5'd21);
    put1(2'd2, 5'd11);
    tick();
    clr_bus();
    put1(2'd2, 5'd12);
    tick();
    exp1("fl_pre", 5'd20);
    chk("fl_pre_stall", 64'(stall1), 64'(4'b0100));
    clr_bus();
    put1(2'd3, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr_bus();
    idle1("fl_t1");
    chk("fl_stall", 64'(stall1), 64'(0));
    tick();
    idle1("fl_t2");
    tick();
    idle1("fl_t3");
    put1(2'd0, 5'd14);
    put1(2'd2, 5'd15);
    tick();
    clr_bus();
    idle1("fl_post_t1");
    tick();
    exp1("fl_post_a", 5'd15);
    tick();
    exp1("fl_post_b", 5'd14);
    tick();
    idle1("fl_post_idle");

    // Asynchronous reset between edges with FIFOs full
    do_reset();
    for (int u = 0; u < 4; u++) put1(2'(u), 5'(24 + u));
    tick();
    tick();
    tick();
    chk("ar_pre_stall", 64'(stall1), 64'(4'b1101));
    exp1("ar_pre", 5'd25);
    #2;
    rst_n = 1'b0;
    clr_bus();
    #1;
    chk("ar_valid", 64'(vld1), 64'(0));
    chk("ar_stall", 64'(stall1), 64'(0));
    chk("ar_rob",   64'(rob1[0]), 64'(0));
    chk("ar_data",  64'(dat1[0]), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      idle1("ar_post_valid");
      chk("ar_post_stall", 64'(stall1), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
